// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with byte lanes and read-modify-write
module load_store_unit #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_hi,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_access_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [15:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state;
    state_t      state_nx;

    // Request fields captured at accept; the live req_* bus is ignored afterwards.
    logic        q_byte;
    logic        q_hi;
    logic        q_signed;
    logic [15:0] q_addr;
    logic [15:0] q_wdata;

    // Word read during the first half of a byte store.
    logic [15:0] word_q;

    // Response payload, held until the response handshake.
    logic [15:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        addr_bad;
    logic [7:0]  load_lane;
    logic [15:0] load_result;
    logic [15:0] merged_word;

    assign accept   = req_valid && (state == S_IDLE);
    assign addr_bad = (req_addr >= DEPTH_W);

    // Byte/word load result formed from the memory word returned in RD.
    always_comb begin
        load_lane = q_hi ? mem_read_data[15:8] : mem_read_data[7:0];
        if (!q_byte) begin
            load_result = mem_read_data;
        end else if (q_signed) begin
            load_result = {{8{load_lane[7]}}, load_lane};
        end else begin
            load_result = {8'h00, load_lane};
        end
    end

    // Byte store: replace only the selected lane of the previously read word.
    always_comb begin
        if (q_hi) begin
            merged_word = {q_wdata[7:0], word_q[7:0]};
        end else begin
            merged_word = {word_q[15:8], q_wdata[7:0]};
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: decode the request at accept, then walk the access sequence.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (addr_bad) begin
                        state_nx = S_RESP;
                    end else if (!req_we) begin
                        state_nx = S_RD;
                    end else if (req_byte) begin
                        state_nx = S_RMW_RD;
                    end else begin
                        state_nx = S_WR;
                    end
                end
            end
            S_RD:     state_nx = S_RESP;
            S_WR:     state_nx = S_RESP;
            S_RMW_RD: state_nx = S_RMW_WR;
            S_RMW_WR: state_nx = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs: strobes and address only in memory states, response only in RESP.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 16'h0000;
        resp_err        = 1'b0;
        mem_access_addr = 16'h0000;
        mem_write_data  = 16'h0000;
        mem_write       = 1'b0;
        mem_read        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_RD: begin
                mem_read        = 1'b1;
                mem_access_addr = q_addr;
            end
            S_WR: begin
                mem_write       = 1'b1;
                mem_access_addr = q_addr;
                mem_write_data  = q_wdata;
            end
            S_RMW_RD: begin
                mem_read        = 1'b1;
                mem_access_addr = q_addr;
            end
            S_RMW_WR: begin
                mem_write       = 1'b1;
                mem_access_addr = q_addr;
                mem_write_data  = merged_word;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Capture request fields on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_byte   <= 1'b0;
            q_hi     <= 1'b0;
            q_signed <= 1'b0;
            q_addr   <= 16'h0000;
            q_wdata  <= 16'h0000;
        end else if (accept) begin
            q_byte   <= req_byte;
            q_hi     <= req_hi;
            q_signed <= req_signed;
            q_addr   <= req_addr;
            q_wdata  <= req_wdata;
        end
    end

    // Hold the old word between the two halves of a byte store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 16'h0000;
        end else if (state == S_RMW_RD) begin
            word_q <= mem_read_data;
        end
    end

    // Response payload: cleared at accept, error flagged immediately, load data at end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= 16'h0000;
            err_q   <= addr_bad;
        end else if (state == S_RD) begin
            rdata_q <= load_result;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_hi = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [15:0] tb_mem [8];
    logic [15:0] ref_mem [8];

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_byte        (req_byte),
        .req_hi          (req_hi),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    assign mem_read_data = (mem_access_addr < 16'd8) ? tb_mem[mem_access_addr[2:0]] : 16'h0000;

    always @(posedge clk) begin
        if (mem_write && mem_access_addr < 16'd8) tb_mem[mem_access_addr[2:0]] = mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request in flight, response after a fixed latency.
    bit          m_busy = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_wval = 16'h0000;
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] m_word;
    logic [7:0]  m_lane;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_addr = 16'h0000;
            m_wval = 16'h0000;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  = 1'b1;
                m_pend  = 1'b0;
                m_rdata = 16'h0000;
                m_err   = 1'b0;
                m_addr  = req_addr;
                m_wval  = 16'h0000;
                if (req_addr >= 16'd8) begin
                    m_err = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_word = ref_mem[req_addr[2:0]];
                    m_lane = req_hi ? m_word[15:8] : m_word[7:0];
                    if (!req_we) begin
                        m_cnt = 1;
                        if (!req_byte) m_rdata = m_word;
                        else if (req_signed) m_rdata = {{8{m_lane[7]}}, m_lane};
                        else m_rdata = {8'h00, m_lane};
                    end else if (!req_byte) begin
                        m_cnt  = 1;
                        m_pend = 1'b1;
                        m_wval = req_wdata;
                    end else begin
                        m_cnt  = 2;
                        m_pend = 1'b1;
                        m_wval = req_hi ? {req_wdata[7:0], m_word[7:0]} : {m_word[15:8], req_wdata[7:0]};
                    end
                end
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && m_pend) ref_mem[m_addr[2:0]] = m_wval;
        end else if (resp_ready) begin
            m_busy = 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_mem_read", mem_read, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_mem_addr", mem_access_addr, 0);
            chk("rst_mem_wdata", mem_write_data, 0);
        end else begin
            chk("req_ready", req_ready, !m_busy);
            chk("resp_valid", resp_valid, m_busy && m_cnt == 0);
            if (m_busy && m_cnt == 0) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", resp_err, m_err);
            end
            chk("strobe_excl", mem_read && mem_write, 0);
            if (mem_read || mem_write) begin
                chk("mem_addr", mem_access_addr, m_addr);
                if (mem_read) rd_cnt++;
                if (mem_write) wr_cnt++;
            end else begin
                chk("mem_addr_idle", mem_access_addr, 0);
            end
            if (mem_write) chk("mem_wdata", mem_write_data, m_wval);
            else chk("mem_wdata_idle", mem_write_data, 0);
        end
    end

    task automatic run(input string name, input logic we, input logic byt, input logic hi,
                       input logic sgn, input logic [15:0] addr, input logic [15:0] wdata,
                       input int hold, input logic [15:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_reads, input int exp_writes);
        int guard;
        int lat;
        logic [15:0] rd;
        logic e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_hi     = hi;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        rd_cnt = 0;
        wr_cnt = 0;
        req_valid  = 1'b0;
        req_addr   = 16'hFFFF;
        req_wdata  = ~wdata;
        req_hi     = ~hi;
        req_signed = ~sgn;
        resp_ready = (hold == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        chk({name, "_resp_seen"}, resp_valid, 1);
        rd = resp_rdata;
        e  = resp_err;
        req_valid = (hold != 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_rdata"}, resp_rdata, rd);
            chk({name, "_hold_err"}, resp_err, e);
            chk({name, "_hold_valid"}, resp_valid, 1);
            chk({name, "_hold_req_ready"}, req_ready, 0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, e, exp_err);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_reads"}, rd_cnt, exp_reads);
        chk({name, "_writes"}, wr_cnt, exp_writes);
        for (int i = 0; i < 8; i++) chk({name, "_mem"}, tb_mem[i], ref_mem[i]);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tb_mem[i]  = (i % 2 == 0) ? 16'h0001 : 16'h0002;
            ref_mem[i] = tb_mem[i];
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //   name         we byt hi sg addr      wdata    hold exp_rd    err lat rd wr
        run("ld_w1",      0, 0, 0, 0, 16'd1,    16'h0,    0, 16'h0002, 0, 2, 1, 0);
        run("st_w3",      1, 0, 0, 0, 16'd3,    16'hBEEF, 0, 16'h0000, 0, 2, 0, 1);
        run("ld_w3",      0, 0, 0, 0, 16'd3,    16'h0,    0, 16'hBEEF, 0, 2, 1, 0);
        run("st_w5",      1, 0, 0, 0, 16'd5,    16'h80F0, 0, 16'h0000, 0, 2, 0, 1);
        run("ld_b5_hs",   0, 1, 1, 1, 16'd5,    16'h0,    0, 16'hFF80, 0, 2, 1, 0);
        run("ld_b5_hu",   0, 1, 1, 0, 16'd5,    16'h0,    0, 16'h0080, 0, 2, 1, 0);
        run("ld_b5_ls",   0, 1, 0, 1, 16'd5,    16'h0,    0, 16'hFFF0, 0, 2, 1, 0);
        run("ld_b5_lu",   0, 1, 0, 0, 16'd5,    16'h0,    0, 16'h00F0, 0, 2, 1, 0);
        run("st_w2",      1, 0, 0, 0, 16'd2,    16'h1234, 0, 16'h0000, 0, 2, 0, 1);
        run("st_b2_hi",   1, 1, 1, 0, 16'd2,    16'h00AB, 0, 16'h0000, 0, 3, 1, 1);
        run("ld_w2_a",    0, 0, 0, 0, 16'd2,    16'h0,    0, 16'hAB34, 0, 2, 1, 0);
        run("st_b2_lo",   1, 1, 0, 0, 16'd2,    16'hFFCD, 0, 16'h0000, 0, 3, 1, 1);
        run("ld_w2_b",    0, 0, 0, 0, 16'd2,    16'h0,    0, 16'hABCD, 0, 2, 1, 0);
        run("ld_err8",    0, 0, 0, 0, 16'h0008, 16'h0,    0, 16'h0000, 1, 1, 0, 0);
        run("st_errff",   1, 1, 1, 0, 16'hFFFF, 16'h1111, 0, 16'h0000, 1, 1, 0, 0);
        run("ld_hold",    0, 0, 0, 0, 16'd0,    16'h0,    4, 16'h0001, 0, 2, 1, 0);
        run("ld_w7",      0, 0, 0, 0, 16'd7,    16'h0,    0, 16'h0002, 0, 2, 1, 0);

        // Reset while the byte store to word 7 is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_hi    = 1'b1;
        req_addr  = 16'd7;
        req_wdata = 16'h0099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_write", mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", mem_write, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_mem_addr", mem_access_addr, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_word7", tb_mem[7], 16'h0002);
        run("ld_w7_post", 0, 0, 0, 0, 16'd7,    16'h0,    0, 16'h0002, 0, 2, 1, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 8, number of 16-bit words in the attached data memory; legal addresses are 0..DEPTH-1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request offered by the pipeline.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 req_hi  input  1  byte lane for byte access: 0 = bits 7:0, 1 = bits 15:8.
REQ-009 req_signed  input  1  byte load: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  16  word address.
REQ-011 req_wdata  input  16  store data; byte store uses bits 7:0.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  pipeline accepts response.
REQ-014 resp_rdata  output  16  load result; 0 for stores and errors.
REQ-015 resp_err  output  1  address out of range.
REQ-016 mem_access_addr  output  16  address to data memory.
REQ-017 mem_write_data  output  16  write data to data memory.
REQ-018 mem_write  output  1  write strobe; memory writes on the rising edge ending the cycle.
REQ-019 mem_read  output  1  read enable; memory returns mem_read_data combinationally in the same cycle.
REQ-020 mem_read_data  input  16  read data from data memory.

Function
REQ-021 States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP; req_ready = 1 only in IDLE.
REQ-022 Request is accepted on a rising edge with req_valid & req_ready; all req_* fields are registered then and ignored until the next IDLE.
REQ-023 From IDLE on accept: req_addr >= DEPTH -> RESP with resp_err=1; word load or byte load -> RD; word store -> WR; byte store -> RMW_RD.
REQ-024 RD: mem_read=1 for exactly one cycle; mem_read_data captured at cycle end; next state RESP.
REQ-025 Word load result = captured word; byte load result = selected byte, bits 15:8 filled with the byte's bit 7 if req_signed else 0.
REQ-026 WR: mem_write=1 for exactly one cycle with mem_write_data = req_wdata; next state RESP.
REQ-027 RMW_RD: mem_read=1 for one cycle, word captured; RMW_WR: mem_write=1 for one cycle with the selected lane replaced by req_wdata[7:0] and the other lane unchanged; then RESP.
REQ-028 mem_access_addr = registered req_addr in RD/WR/RMW_RD/RMW_WR, else 0; mem_write_data = 0 outside WR/RMW_WR.
REQ-029 mem_read and mem_write are never both 1; no memory strobe is issued for an out-of-range request.
REQ-030 Latency from accept edge to resp_valid: error 1 cycle, load/word store 2 cycles, byte store 3 cycles.
REQ-031 RESP: resp_valid=1 with resp_rdata/resp_err stable until resp_valid & resp_ready; next state IDLE; req_ready rises the cycle after handshake (no same-cycle accept).
REQ-032 resp_ready is ignored outside RESP; req_valid is ignored outside IDLE.

Reset
REQ-033 rst_n low immediately forces IDLE and drives req_ready=1 (while rst_n high follows), resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_access_addr=0, mem_write_data=0.
REQ-034 Reset asserted in any state, including WR or RMW_WR, aborts the operation; no memory write occurs on any edge while rst_n is low, and no response is produced for the aborted request.
REQ-035 After rst_n deasserts, the first rising edge may accept a request.

Verification
REQ-036 Memory words 0..7 = 1,2,1,2,1,2,1,2; word load addr 1 -> resp_rdata=16'h0002, resp_err=0, resp_valid 2 cycles after accept.
REQ-037 Word store 16'hBEEF to addr 3, then word load addr 3 -> 16'hBEEF; mem_write high exactly one cycle.
REQ-038 Word 5 = 16'h80F0; byte load hi signed -> 16'hFF80; hi unsigned -> 16'h0080; lo signed -> 16'hFFF0.
REQ-039 Word 2 = 16'h1234; byte store 16'h00AB hi -> word 2 = 16'hAB34, resp 3 cycles after accept; lo byte store 16'h00CD -> 16'hABCD.
REQ-040 Load addr 16'h0008 -> resp_err=1, resp_rdata=0, no mem_read/mem_write, resp 1 cycle after accept.
REQ-041 Hold resp_ready=0 for 4 cycles -> resp_valid and data stable, req_ready=0; assert rst_n low during RMW_WR -> target word unchanged, all outputs at reset values.
